aes_decrypt_iter: RTL and testbench

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

---
 rtl/aes_decrypt_iter.sv | 269 ++++++++++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - Iterative AES-128 inverse cipher, one round per clock
//
// Purpose : FIPS-197 AES-128 decryption. The cipher key is expanded forward
//           to round key 10, then the rounds run 9..0 while the key schedule
//           is walked backwards one step per round.
// Ports   : clk      - clock, rising edge
//           reset_n  - asynchronous active-low reset
//           start    - request pulse, sampled only in IDLE when done is low
//           ct_in    - 128-bit ciphertext, bit 127 is byte 0
//           key_in   - 128-bit cipher key, bit 127 is byte 0
//           pt_out   - registered plaintext, zero unless a result is valid
//           busy     - high while a block is being processed
//           done     - one-cycle pulse when pt_out becomes valid
// Build   : AES_DEC_KEY_CACHE_EN keeps the last key and its round key 10 so
//           that a repeat key skips expansion (11 instead of 21 clocks).

module aes_gf_inv (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] sq;
   logic [7:0] acc;

   // a^254 is the multiplicative inverse; zero maps to zero as the S-box needs
   always_comb begin
      sq  = a_i;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      y_o = acc;
   end
endmodule

module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   logic [7:0] inv;
   aes_gf_inv u_inv (.a_i(a_i), .y_o(inv));
   assign y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   logic [7:0] pre;
   assign pre = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
   aes_gf_inv u_inv (.a_i(pre), .y_o(y_o));
endmodule

module aes_decrypt_iter (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [127:0] ct_in,
   input  logic [127:0] key_in,
   output logic [127:0] pt_out,
   output logic         busy,
   output logic         done
);
   typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, FINISH} state_e;

   state_e       fsm_q;
   logic [3:0]   rnd_q;
   logic [127:0] state_q;
   logic [127:0] key_q;
   logic [127:0] pt_q;
   logic         busy_q;
   logic         done_q;

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0]  m9  [0:3];
      logic [7:0]  m11 [0:3];
      logic [7:0]  m13 [0:3];
      logic [7:0]  m14 [0:3];
      logic [7:0]  a, x2, x4, x8;
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         a  = col[31-8*i -: 8];
         x2 = xt(a);
         x4 = xt(x2);
         x8 = xt(x4);
         m9[i]  = x8 ^ a;
         m11[i] = x8 ^ x2 ^ a;
         m13[i] = x8 ^ x4 ^ a;
         m14[i] = x8 ^ x4 ^ x2;
      end
      // circulant matrix: row j is {14,11,13,9} rotated right by j
      for (int j = 0; j < 4; j++)
         res[31-8*j -: 8] = m14[j] ^ m11[(j+1)%4] ^ m13[(j+2)%4] ^ m9[(j+3)%4];
      return res;
   endfunction

   // ---------------- key schedule (4 shared forward S-boxes) ----------------
   logic [31:0]  kw0, kw1, kw2, kw3;
   logic [31:0]  sub_in, sub_out, rot_sub;
   logic [31:0]  p3;
   logic [3:0]   rcon_idx;
   logic [127:0] key_fwd_d;
   logic [127:0] key_inv_d;

   assign {kw0, kw1, kw2, kw3} = key_q;
   assign rcon_idx = rnd_q + 4'd1;
   // going backwards, word 3 of the previous key is w2^w3 of the current one
   assign p3     = kw2 ^ kw3;
   assign sub_in = (fsm_q == ROUND) ? p3 : kw3;

   for (genvar i = 0; i < 4; i++) begin : g_ksbox
      aes_sbox u_sbox (.a_i(sub_in[8*i +: 8]), .y_o(sub_out[8*i +: 8]));
   end

   assign rot_sub = {sub_out[23:0], sub_out[31:24]} ^ {rcon(rcon_idx), 24'h000000};

   always_comb begin
      key_fwd_d[127:96] = kw0 ^ rot_sub;
      key_fwd_d[95:64]  = kw1 ^ key_fwd_d[127:96];
      key_fwd_d[63:32]  = kw2 ^ key_fwd_d[95:64];
      key_fwd_d[31:0]   = kw3 ^ key_fwd_d[63:32];
   end

   assign key_inv_d = {kw0 ^ rot_sub, kw0 ^ kw1, kw1 ^ kw2, p3};

   // ---------------- data path (16 inverse S-boxes) ----------------
   logic [127:0] isr, isb, ark, imc, round_d;

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int SRC = 4*((c - r + 4) % 4) + r;
         localparam int DST = 4*c + r;
         assign isr[127-8*DST -: 8] = state_q[127-8*SRC -: 8];
         aes_inv_sbox u_isbox (.a_i(isr[127-8*DST -: 8]), .y_o(isb[127-8*DST -: 8]));
      end
      assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
   end

   assign ark     = isb ^ key_inv_d;
   assign round_d = (rnd_q == 4'd0) ? ark : imc;

   // ---------------- optional round-key-10 cache ----------------
   logic         start_ok;
   logic         cache_hit;
   logic [127:0] cache_rk10;

   assign start_ok = (fsm_q == IDLE) && start && !done_q;

`ifdef AES_DEC_KEY_CACHE_EN
   logic [127:0] ckey_q;
   logic [127:0] crk_q;
   logic         cvld_q;

   assign cache_hit  = cvld_q && (key_in == ckey_q);
   assign cache_rk10 = crk_q;

   // the key is captured at start but only trusted once rk10 is written
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ckey_q <= '0;
         crk_q  <= '0;
         cvld_q <= 1'b0;
      end else if (start_ok && !cache_hit) begin
         ckey_q <= key_in;
         cvld_q <= 1'b0;
      end else if (fsm_q == KEYEXP && rnd_q == 4'd9) begin
         crk_q  <= key_fwd_d;
         cvld_q <= 1'b1;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_rk10 = '0;
`endif

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q   <= IDLE;
         rnd_q   <= 4'd0;
         state_q <= '0;
         key_q   <= '0;
         pt_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (fsm_q)
            IDLE: begin
               if (start_ok) begin
                  busy_q <= 1'b1;
                  pt_q   <= '0;
                  if (cache_hit) begin
                     state_q <= ct_in ^ cache_rk10;
                     key_q   <= cache_rk10;
                     rnd_q   <= 4'd9;
                     fsm_q   <= ROUND;
                  end else begin
                     // ciphertext parks in state_q until rk10 is known
                     state_q <= ct_in;
                     key_q   <= key_in;
                     rnd_q   <= 4'd0;
                     fsm_q   <= KEYEXP;
                  end
               end
            end
            KEYEXP: begin
               key_q <= key_fwd_d;
               if (rnd_q == 4'd9) begin
                  state_q <= state_q ^ key_fwd_d;
                  fsm_q   <= ROUND;
               end else begin
                  rnd_q <= rnd_q + 4'd1;
               end
            end
            ROUND: begin
               state_q <= round_d;
               key_q   <= key_inv_d;
               if (rnd_q == 4'd0) fsm_q <= FINISH;
               else               rnd_q <= rnd_q - 4'd1;
            end
            FINISH: begin
               pt_q   <= state_q;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               fsm_q  <= IDLE;
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign pt_out = pt_q;
   assign busy   = busy_q;
   assign done   = done_q;
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb/tb_aes_decrypt_iter.sv - Self-checking bench for aes_decrypt_iter

module tb_aes_decrypt_iter;
   logic         clk;
   logic         reset_n;
   logic         start;
   logic [127:0] ct_in;
   logic [127:0] key_in;
   logic [127:0] pt_out;
   logic         busy;
   logic         done;

`ifdef AES_DEC_KEY_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

   int           n_run;
   int           n_fail;
   int           seen;
   bit           c_vld;
   logic [127:0] c_key;
   logic [127:0] rk, rc;
   logic [7:0]   sbox  [0:255];
   logic [7:0]   isbox [0:255];

   aes_decrypt_iter dut (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start),
      .ct_in  (ct_in),
      .key_in (key_in),
      .pt_out (pt_out),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from walking the multiplicative group with generator 3
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      for (int n = 0; n < 255; n++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox[p] = x ^ 8'h63;
      end
      sbox[0] = 8'h63;
      for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
   endtask

   function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
      logic [31:0]  w [0:43];
      logic [7:0]   s [0:15];
      logic [7:0]   t [0:15];
      logic [7:0]   a0, a1, a2, a3;
      logic [31:0]  tmp, wd;
      logic [7:0]   rcv;
      logic [127:0] res;
      rcv = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rcv, 24'h0};
            rcv = gmul(rcv, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) begin
         wd = w[40 + i/4];
         s[i] = ct[127-8*i -: 8] ^ wd[31-8*(i%4) -: 8];
      end
      for (int rnd = 9; rnd >= 0; rnd--) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[4*c+r] = s[4*((c-r+4)%4)+r];
         for (int i = 0; i < 16; i++) begin
            wd = w[4*rnd + i/4];
            s[i] = isbox[t[i]] ^ wd[31-8*(i%4) -: 8];
         end
         if (rnd > 0) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0,8'd14) ^ gmul(a1,8'd11) ^ gmul(a2,8'd13) ^ gmul(a3,8'd9);
               s[4*c+1] = gmul(a0,8'd9)  ^ gmul(a1,8'd14) ^ gmul(a2,8'd11) ^ gmul(a3,8'd13);
               s[4*c+2] = gmul(a0,8'd13) ^ gmul(a1,8'd9)  ^ gmul(a2,8'd14) ^ gmul(a3,8'd11);
               s[4*c+3] = gmul(a0,8'd11) ^ gmul(a1,8'd13) ^ gmul(a2,8'd9)  ^ gmul(a3,8'd14);
            end
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic do_run(input string tag, input logic [127:0] key, input logic [127:0] ct,
                         input bit disturb, input bit start_at_done);
      logic [127:0] exp_pt;
      logic [127:0] res;
      int           exp_lat;
      int           lat;
      int           bad;
      exp_pt  = ref_decrypt(key, ct);
      exp_lat = (CACHE_EN && c_vld && key == c_key) ? 11 : 21;
      @(negedge clk);
      key_in = key;
      ct_in  = ct;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      bad = 0;
      lat = 0;
      if (busy !== 1'b1 || pt_out !== '0) bad++;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (disturb && lat == 5) begin
            start  = 1'b1;
            ct_in  = ~ct;
            key_in = ~key;
         end
         if (disturb && lat == 6) start = 1'b0;
         if (done === 1'b1) break;
         if (busy !== 1'b1 || pt_out !== '0) bad++;
      end
      check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
      check({tag, "_pt"}, pt_out, exp_pt);
      check({tag, "_busy_run"}, 128'(bad), 128'd0);
      check({tag, "_busy_at_done"}, 128'(busy), 128'd0);
      res = pt_out;
      if (start_at_done) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_done_busy_after"}, 128'({done, busy}), 128'd0);
      check({tag, "_hold"}, pt_out, res);
      c_key = key;
      c_vld = 1'b1;
   endtask

   initial begin
      n_run   = 0;
      n_fail  = 0;
      c_vld   = 1'b0;
      c_key   = '0;
      start   = 1'b0;
      ct_in   = '0;
      key_in  = '0;
      reset_n = 1'b0;
      build_sbox();
      check("model_c1", ref_decrypt(K1, C1), P1);
      check("model_appb", ref_decrypt(K2, C2), P2);

      repeat (3) @(posedge clk);
      #1;
      check("rst_pt", pt_out, 128'd0);
      check("rst_busy_done", 128'({busy, done}), 128'd0);
      @(negedge clk);
      reset_n = 1'b1;

      do_run("c1", K1, C1, 1'b0, 1'b0);
      do_run("c1_again", K1, C1, 1'b0, 1'b0);
      do_run("appb", K2, C2, 1'b0, 1'b1);
      rk = {$urandom, $urandom, $urandom, $urandom};
      rc = {$urandom, $urandom, $urandom, $urandom};
      do_run("busy_dist", rk, rc, 1'b1, 1'b0);

      // reset in ROUND r=4 aborts the run
      @(negedge clk);
      key_in = K1;
      ct_in  = C1;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_busy_done", 128'({busy, done}), 128'd0);
      check("midrst_pt", pt_out, 128'd0);
      c_vld = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen++;
      end
      check("midrst_no_done", 128'(seen), 128'd0);
      do_run("c1_after_rst", K1, C1, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         rk = ($urandom_range(0, 1) == 1) ? c_key : {$urandom, $urandom, $urandom, $urandom};
         rc = {$urandom, $urandom, $urandom, $urandom};
         do_run($sformatf("rnd%0d", i), rk, rc, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
